// File: rtl/path_follower.sv
// Replays backtraced direction codes from path memory as a paced, handshaked move stream,
// tracking the runner position and flagging malformed paths or paths that miss the goal.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | path memory read strobe for index rptr
// WAIT  | read data arrives, latched into dir_q
// CHECK | validate code, grid bounds and wall at target cell
// EMIT  | move offered downstream until move_ready
// PACE  | inter-move gap of STEP_CYCLES cycles
// FINAL | compare final position with goal
// DONE  | path completed at goal
// ERR   | fault latched in err_code
module path_follower #(
    parameter int START_ROW   = 9,
    parameter int START_COL   = 0,
    parameter int GOAL_ROW    = 0,
    parameter int GOAL_COL    = 9,
    parameter int STEP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  path_length,
    input  logic [0:99] maze,
    output logic        path_read_en,
    output logic [6:0]  path_read_index,
    input  logic [3:0]  path_read_data,
    output logic        move_valid,
    output logic [3:0]  move_dir,
    input  logic        move_ready,
    output logic [3:0]  pos_row,
    output logic [3:0]  pos_col,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam logic [3:0] START_R   = 4'(START_ROW);
    localparam logic [3:0] START_C   = 4'(START_COL);
    localparam logic [3:0] GOAL_R    = 4'(GOAL_ROW);
    localparam logic [3:0] GOAL_C    = 4'(GOAL_COL);
    localparam logic [7:0] PACE_LOAD = 8'(STEP_CYCLES);

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT, CHECK, EMIT, PACE, FINAL, DONE, ERR
    } state_t;

    state_t     state;
    logic [6:0] rptr;
    logic [6:0] len;
    logic [3:0] dir_q;
    logic [7:0] pace_cnt;

    logic       dir_ok;
    logic       off_grid;
    logic       wall;
    logic [3:0] t_row;
    logic [3:0] t_col;
    logic [6:0] cell_idx;

    always_comb begin
        path_read_en    = (state == FETCH);
        path_read_index = path_read_en ? rptr : 7'd0;
        move_valid      = (state == EMIT);
        move_dir        = move_valid ? dir_q : 4'd0;
        busy            = !(state == IDLE || state == DONE || state == ERR);
    end

    // Target cell of the pending move; the wall lookup is only meaningful on-grid.
    always_comb begin
        dir_ok   = 1'b1;
        off_grid = 1'b0;
        t_row    = pos_row;
        t_col    = pos_col;
        case (dir_q)
            DIR_UP:    begin off_grid = (pos_row == 4'd0); t_row = pos_row - 4'd1; end
            DIR_DOWN:  begin off_grid = (pos_row == 4'd9); t_row = pos_row + 4'd1; end
            DIR_LEFT:  begin off_grid = (pos_col == 4'd0); t_col = pos_col - 4'd1; end
            DIR_RIGHT: begin off_grid = (pos_col == 4'd9); t_col = pos_col + 4'd1; end
            default:   dir_ok = 1'b0;
        endcase
        cell_idx = (off_grid || !dir_ok) ? 7'd0
                                         : ({3'd0, t_row} * 7'd10 + {3'd0, t_col});
        wall     = dir_ok && !off_grid && maze[cell_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rptr     <= 7'd0;
            len      <= 7'd0;
            dir_q    <= 4'd0;
            pace_cnt <= 8'd0;
            pos_row  <= START_R;
            pos_col  <= START_C;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= 3'd0;
                        len      <= path_length;
                        rptr     <= 7'd0;
                        pos_row  <= START_R;
                        pos_col  <= START_C;
                        if (path_length == 7'd0) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= 3'd1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    dir_q <= path_read_data;
                    state <= CHECK;
                end
                CHECK: begin
                    if (!dir_ok) begin
                        state <= ERR; err <= 1'b1; err_code <= 3'd2;
                    end else if (off_grid) begin
                        state <= ERR; err <= 1'b1; err_code <= 3'd3;
                    end else if (wall) begin
                        state <= ERR; err <= 1'b1; err_code <= 3'd4;
                    end else begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (move_ready) begin
                        pos_row  <= t_row;
                        pos_col  <= t_col;
                        rptr     <= rptr + 7'd1;
                        pace_cnt <= PACE_LOAD;
                        if (STEP_CYCLES == 0)
                            state <= ((rptr + 7'd1) < len) ? FETCH : FINAL;
                        else
                            state <= PACE;
                    end
                end
                PACE: begin
                    if (pace_cnt <= 8'd1)
                        state <= (rptr < len) ? FETCH : FINAL;
                    else
                        pace_cnt <= pace_cnt - 8'd1;
                end
                FINAL: begin
                    if (pos_row == GOAL_R && pos_col == GOAL_C) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= ERR;
                        err      <= 1'b1;
                        err_code <= 3'd5;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_follower.sv
// Bench for path_follower: a behavioural path model fills a move scoreboard that a
// negedge monitor drains on each handshake; runs end with status, latency and read checks.
module tb_path_follower;

    localparam int STEP  = 4;
    localparam int LIMIT = 3000;

    localparam logic [3:0] UP    = 4'b0001;
    localparam logic [3:0] DOWN  = 4'b0010;
    localparam logic [3:0] LEFT  = 4'b0100;
    localparam logic [3:0] RIGHT = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  path_length = 7'd0;
    logic [0:99] maze = '0;
    logic        path_read_en;
    logic [6:0]  path_read_index;
    logic [3:0]  path_read_data = 4'd0;
    logic        move_valid;
    logic [3:0]  move_dir;
    logic        move_ready = 1'b1;
    logic [3:0]  pos_row;
    logic [3:0]  pos_col;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    path_follower #(
        .START_ROW(9), .START_COL(0), .GOAL_ROW(0), .GOAL_COL(9), .STEP_CYCLES(STEP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .path_length(path_length), .maze(maze),
        .path_read_en(path_read_en), .path_read_index(path_read_index),
        .path_read_data(path_read_data), .move_valid(move_valid), .move_dir(move_dir),
        .move_ready(move_ready), .pos_row(pos_row), .pos_col(pos_col), .busy(busy),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] mem [0:127];
    always @(posedge clk) if (path_read_en) path_read_data <= mem[path_read_index];

    typedef struct { logic [3:0] dir; int row; int col; } mv_t;
    mv_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int hs_count = 0;
    int stall_cnt = 0;
    int stall_idx = -1;
    int stall_left = 0;
    int reads = 0;
    int start_cyc = 0;
    bit rand_ready = 0;
    bit mon_en = 0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference walk over the stored codes; pushes every move that should be emitted.
    task automatic build_model(input int len, output int code, output int fr,
                               output int fc, output int nmv);
        int r, c, nr, nc;
        r = 9; c = 0; code = 0; nmv = 0;
        if (len == 0) code = 1;
        for (int i = 0; i < len && code == 0; i++) begin
            nr = r; nc = c;
            case (mem[i])
                UP:      nr = r - 1;
                DOWN:    nr = r + 1;
                LEFT:    nc = c - 1;
                RIGHT:   nc = c + 1;
                default: code = 2;
            endcase
            if (code == 0 && (nr < 0 || nr > 9 || nc < 0 || nc > 9)) code = 3;
            else if (code == 0 && maze[nr*10 + nc]) code = 4;
            if (code == 0) begin
                exp_q.push_back('{dir: mem[i], row: r, col: c});
                r = nr; c = nc; nmv++;
            end
        end
        if (code == 0 && !(r == 0 && c == 9)) code = 5;
        fr = r; fc = c;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && move_valid && hs_count == stall_idx) begin
                move_ready = 1'b0;
                stall_left--;
                stall_cnt++;
            end else if (rand_ready && move_valid) begin
                move_ready = ($urandom_range(0, 3) != 0);
                if (!move_ready) stall_cnt++;
            end else begin
                move_ready = 1'b1;
            end
        end
    end

    bit         prev_valid = 0;
    bit         prev_ready = 0;
    logic [3:0] prev_dir = 4'd0;
    int         prev_row = 0;
    int         prev_col = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (move_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_move", 1, 0);
                end else if (move_ready) begin
                    mv_t mv;
                    mv = exp_q.pop_front();
                    check("move_dir", move_dir, mv.dir);
                    check("pre_row", pos_row, mv.row);
                    check("pre_col", pos_col, mv.col);
                    check("hs_cycle", cyc - start_cyc, 3 + hs_count*(4 + STEP) + stall_cnt);
                    hs_count++;
                end
            end else begin
                check("idle_dir_zero", move_dir, 0);
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", move_valid, 1);
                check("hold_dir", move_dir, prev_dir);
                check("hold_row", pos_row, prev_row);
                check("hold_col", pos_col, prev_col);
            end
            if (path_read_en) reads++;
        end
        prev_valid = move_valid;
        prev_ready = move_ready;
        prev_dir   = move_dir;
        prev_row   = pos_row;
        prev_col   = pos_col;
    end

    task automatic reset_dut();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic run_case(string name, int len);
        int code, fr, fc, nmv, lat, reads_exp, k;
        exp_q.delete();
        build_model(len, code, fr, fc, nmv);
        lat       = (code == 1) ? 0 : (code >= 2 && code <= 4) ? nmv*(4 + STEP) + 3
                                                                : nmv*(4 + STEP) + 1;
        reads_exp = (code == 1) ? 0 : (code >= 2 && code <= 4) ? nmv + 1 : nmv;
        @(posedge clk); #1;
        hs_count = 0; stall_cnt = 0; reads = 0;
        path_length = 7'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_cyc = cyc;
        k = 0;
        while (!(done || err) && k < LIMIT) begin
            @(posedge clk); #1; k++;
        end
        if (k >= LIMIT) begin
            check({name, " terminal"}, 0, 1);
            reset_dut();
        end else begin
            check({name, " latency"}, k, lat + stall_cnt);
            check({name, " done"}, done, (code == 0) ? 1 : 0);
            check({name, " err"}, err, (code != 0) ? 1 : 0);
            check({name, " err_code"}, err_code, code);
            check({name, " row"}, pos_row, fr);
            check({name, " col"}, pos_col, fc);
            check({name, " busy"}, busy, 0);
            check({name, " moves_left"}, exp_q.size(), 0);
            check({name, " reads"}, reads, reads_exp);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic load_goal_path();
        for (int i = 0; i < 9; i++) mem[i] = UP;
        for (int i = 9; i < 18; i++) mem[i] = RIGHT;
    endtask

    task automatic reset_mid();
        int code, fr, fc, nmv, k;
        exp_q.delete();
        build_model(18, code, fr, fc, nmv);
        @(posedge clk); #1;
        hs_count = 0; stall_cnt = 0;
        path_length = 7'd18; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_cyc = cyc;
        k = 0;
        while (hs_count < 3 && k < LIMIT) begin
            @(negedge clk); k++;
        end
        check("t6 reached_move3", (hs_count >= 3) ? 1 : 0, 1);
        @(posedge clk); #1;
        check("t6 busy_in_pace", busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        check("t6 busy", busy, 0);
        check("t6 move_valid", move_valid, 0);
        check("t6 row", pos_row, 9);
        check("t6 col", pos_col, 0);
        check("t6 done", done, 0);
        check("t6 err", err, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 4'd0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset err_code", err_code, 0);
        check("reset row", pos_row, 9);
        check("reset col", pos_col, 0);
        check("reset move_valid", move_valid, 0);
        check("reset read_en", path_read_en, 0);
        check("reset read_index", path_read_index, 0);
        rst = 1'b1;
        mon_en = 1;

        maze = '0;
        load_goal_path();
        run_case("t1 goal", 18);

        stall_idx = 2; stall_left = 5;
        run_case("t2 stall", 18);
        stall_idx = -1;

        maze[80] = 1'b1;
        run_case("t3 wall", 18);
        maze[80] = 1'b0;

        mem[2] = 4'b0011;
        run_case("t4 bad_code", 18);
        mem[2] = UP;
        mem[0] = DOWN;
        run_case("t4 oob", 18);
        mem[0] = UP;

        run_case("t5 len0", 0);
        run_case("t5 short", 5);

        reset_mid();
        run_case("t6 replay", 18);

        rand_ready = 1;
        for (int n = 0; n < 4; n++) begin
            int a, b;
            logic [3:0] t;
            load_goal_path();
            for (int i = 17; i > 0; i--) begin
                a = i; b = $urandom_range(0, i);
                t = mem[a]; mem[a] = mem[b]; mem[b] = t;
            end
            maze = '0;
            if (n >= 2) for (int i = 0; i < 100; i++) maze[i] = ($urandom_range(0, 9) == 0);
            run_case("rand goal", 18);
        end
        for (int n = 0; n < 20; n++) begin
            int len, sel;
            for (int i = 0; i < 100; i++) maze[i] = ($urandom_range(0, 7) == 0);
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                sel = $urandom_range(0, 19);
                case (sel % 6)
                    0, 1:    mem[i] = UP;
                    2, 3:    mem[i] = RIGHT;
                    4:       mem[i] = DOWN;
                    default: mem[i] = LEFT;
                endcase
                if (sel == 19) mem[i] = 4'($urandom_range(0, 15));
            end
            run_case("rand walk", len);
        end
        rand_ready = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
